// File: rtl/sum_game_round_ctrl.sv
// Round sequencer for the scrambled-number sum game.
// Walks one round: ROM fetch of operand 1, ld1 strobe, wait for the player's
// operand 2, ld2 strobe, sum check against the target, timed LED display.
// Optional build macro: ROUND_TIMEOUT_EN adds a WAIT2 timeout that forces a loss.
// Handshake note: button_pulse is a one-cycle strobe that is acted on only in
// IDLE and WAIT2; everywhere else it is dropped and never queued.
module sum_game_round_ctrl #(
    parameter int ROM_LAT        = 1,
    parameter int RESULT_CYCLES  = 50,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button_pulse,
    input  logic [3:0]       toggle_switch,
    input  logic [3:0]       switch_num2,
    input  logic [4:0]       target_sum,
    input  logic [3:0]       rom_q,
    output logic [3:0]       rom_addr,
    output logic             ld1,
    output logic             ld2,
    output logic [3:0]       num1,
    output logic [3:0]       num2,
    output logic [4:0]       sum,
    output logic             green_led,
    output logic             red_led,
    output logic [CNT_W-1:0] round_cnt,
    output logic [CNT_W-1:0] score,
    output logic             busy
);

    // One shared down-counter times FETCH, RESULT and (optionally) WAIT2.
    localparam int MAX_A = (ROM_LAT > RESULT_CYCLES) ? ROM_LAT : RESULT_CYCLES;
`ifdef ROUND_TIMEOUT_EN
    localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
`else
    localparam int MAX_CNT = MAX_A;
`endif
    localparam int CW = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD1, S_WAIT2, S_LOAD2, S_CHECK, S_RESULT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       rom_addr_q, rom_addr_d;
    logic [3:0]       num1_q, num1_d;
    logic [3:0]       num2_q, num2_d;
    logic [4:0]       sum_q, sum_d;
    logic             green_q, green_d;
    logic             red_q, red_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [CNT_W-1:0] score_q, score_d;
    logic             win;
`ifdef ROUND_TIMEOUT_EN
    logic             loss_q, loss_d;
`endif

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            num1_q     <= '0;
            num2_q     <= '0;
            sum_q      <= '0;
            green_q    <= 1'b0;
            red_q      <= 1'b0;
            round_q    <= '0;
            score_q    <= '0;
`ifdef ROUND_TIMEOUT_EN
            loss_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            sum_q      <= sum_d;
            green_q    <= green_d;
            red_q      <= red_d;
            round_q    <= round_d;
            score_q    <= score_d;
`ifdef ROUND_TIMEOUT_EN
            loss_q     <= loss_d;
`endif
        end
    end

    // Next-state and register-update logic for the round sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        sum_d      = sum_q;
        green_d    = green_q;
        red_d      = red_q;
        round_d    = round_q;
        score_d    = score_q;
        win        = 1'b0;
`ifdef ROUND_TIMEOUT_EN
        loss_d     = loss_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (button_pulse) begin
                    rom_addr_d = toggle_switch;
                    cnt_d      = CW'(ROM_LAT - 1);
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (cnt_q == '0) begin
                    num1_d  = rom_q;
                    state_d = S_LOAD1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_LOAD1: begin
                state_d = S_WAIT2;
`ifdef ROUND_TIMEOUT_EN
                cnt_d   = CW'(TIMEOUT_CYCLES - 1);
                loss_d  = 1'b0;
`endif
            end
            S_WAIT2: begin
                if (button_pulse) begin
                    num2_d  = switch_num2;
                    state_d = S_LOAD2;
`ifdef ROUND_TIMEOUT_EN
                end else if (cnt_q == '0) begin
                    loss_d  = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
`endif
                end
            end
            S_LOAD2: begin
                sum_d   = {1'b0, num1_q} + {1'b0, num2_q};
                state_d = S_CHECK;
            end
            S_CHECK: begin
                win = (sum_q == target_sum);
`ifdef ROUND_TIMEOUT_EN
                if (loss_q) win = 1'b0;
`endif
                if (win) begin
                    green_d = 1'b1;
                    if (score_q != '1) score_d = score_q + CNT_W'(1);
                end else begin
                    red_d = 1'b1;
                end
                round_d = round_q + CNT_W'(1);
                cnt_d   = CW'(RESULT_CYCLES - 1);
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (cnt_q == '0) begin
                    green_d = 1'b0;
                    red_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rom_addr  = rom_addr_q;
    assign ld1       = (state_q == S_LOAD1);
    assign ld2       = (state_q == S_LOAD2);
    assign num1      = num1_q;
    assign num2      = num2_q;
    assign sum       = sum_q;
    assign green_led = green_q;
    assign red_led   = red_q;
    assign round_cnt = round_q;
    assign score     = score_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sum_game_round_ctrl.sv
// Bench for sum_game_round_ctrl: random rounds against a game-rule model,
// scoreboard queues popped by a monitor on ld1/ld2/LED events.
module tb_sum_game_round_ctrl;

  localparam int ROM_LAT        = 1;
  localparam int RESULT_CYCLES  = 50;
  localparam int CNT_W          = 4;
  localparam int TIMEOUT_CYCLES = 10;
  localparam int RW             = 2 + 5 + 2 * CNT_W;
  localparam int CNT_MAX        = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             button_pulse;
  logic [3:0]       toggle_switch;
  logic [3:0]       switch_num2;
  logic [4:0]       target_sum;
  logic [3:0]       rom_q;
  logic [3:0]       rom_addr;
  logic             ld1;
  logic             ld2;
  logic [3:0]       num1;
  logic [3:0]       num2;
  logic [4:0]       sum;
  logic             green_led;
  logic             red_led;
  logic [CNT_W-1:0] round_cnt;
  logic [CNT_W-1:0] score;
  logic             busy;

  sum_game_round_ctrl #(
    .ROM_LAT(ROM_LAT),
    .RESULT_CYCLES(RESULT_CYCLES),
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .button_pulse(button_pulse),
    .toggle_switch(toggle_switch), .switch_num2(switch_num2),
    .target_sum(target_sum), .rom_q(rom_q), .rom_addr(rom_addr),
    .ld1(ld1), .ld2(ld2), .num1(num1), .num2(num2), .sum(sum),
    .green_led(green_led), .red_led(red_led), .round_cnt(round_cnt),
    .score(score), .busy(busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  // puzzle ROM: data is valid at the first edge after the address changes
  logic [3:0] rom_mem [16];
  assign rom_q = rom_mem[rom_addr];

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [3:0]    exp_num1_q[$];
  logic [3:0]    exp_num2_q[$];
  logic [RW-1:0] exp_q[$];

  // game-rule model
  int         m_score;
  int         m_rounds;
  logic [3:0] m_num1;
  logic [4:0] m_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a strobe or result
  int   led_len = 0;
  logic led_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      led_len  = 0;
      led_prev = 1'b0;
    end else begin
      check("ld_exclusive", 32'(ld1 & ld2), 32'd0);
      check("led_exclusive", 32'(green_led & red_led), 32'd0);
      if (ld1) begin
        if (exp_num1_q.size() == 0) check("ld1_unexpected", 32'd1, 32'd0);
        else check("num1", 32'(num1), 32'(exp_num1_q.pop_front()));
      end
      if (ld2) begin
        if (exp_num2_q.size() == 0) check("ld2_unexpected", 32'd1, 32'd0);
        else check("num2", 32'(num2), 32'(exp_num2_q.pop_front()));
      end
      if ((green_led | red_led) && !led_prev) begin
        if (exp_q.size() == 0) check("result_unexpected", 32'd1, 32'd0);
        else check("result{g,r,sum,score,rounds}",
                   32'({green_led, red_led, sum, score, round_cnt}), 32'(exp_q.pop_front()));
        led_len = 1;
      end else if (green_led | red_led) begin
        led_len++;
      end else if (led_prev) begin
        check("led_hold_cycles", 32'(led_len), 32'(RESULT_CYCLES));
        check("busy_after_result", 32'(busy), 32'd0);
      end
      led_prev = green_led | red_led;
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin tick(); n++; end
    if (n >= 500) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic push_result(input bit g, input bit r);
    exp_q.push_back({g, r, m_sum, CNT_W'(m_score), CNT_W'(m_rounds)});
  endtask

  task automatic start_round(input logic [3:0] addr);
    int n = 0;
    wait_idle();
    toggle_switch = addr;
    m_num1 = rom_mem[addr];
    exp_num1_q.push_back(m_num1);
    button_pulse = 1'b1;
    do begin
      tick();
      button_pulse = 1'b0;
      toggle_switch = 4'($urandom_range(0, 15));
      n++;
    end while (!ld1 && n < 20);
    check("press_to_ld1", 32'(n), 32'(ROM_LAT + 1));
  endtask

  // idle_cyc >= 1: number of WAIT2 cycles before the press cycle is reached
  task automatic finish_round(input logic [3:0] n2, input logic [4:0] tgt,
                              input int idle_cyc, input bit extra);
    int n;
    bit win;
    logic [4:0] s;
    for (int i = 0; i < idle_cyc; i++) begin
      target_sum = 5'($urandom_range(0, 31));
      switch_num2 = 4'($urandom_range(0, 15));
      tick();
    end
    target_sum = tgt;
    switch_num2 = n2;
    s = 5'(m_num1) + 5'(n2);
    win = (s == tgt);
    m_sum = s;
    if (win && m_score < CNT_MAX) m_score++;
    m_rounds = (m_rounds + 1) % (CNT_MAX + 1);
    exp_num2_q.push_back(n2);
    push_result(win, !win);
    button_pulse = 1'b1;
    n = 0;
    do begin
      tick();
      button_pulse = 1'b0;
      switch_num2 = 4'($urandom_range(0, 15));
      n++;
    end while (!ld2 && n < 10);
    check("press_to_ld2", 32'(n), 32'd1);
    n = 0;
    do begin tick(); n++; end while (!(green_led | red_led) && n < 10);
    check("ld2_to_led", 32'(n), 32'd2);
    target_sum = 5'($urandom_range(0, 31));
    if (extra) begin
      repeat ($urandom_range(3, RESULT_CYCLES - 10)) tick();
      button_pulse = 1'b1;
      tick();
      button_pulse = 1'b0;
    end
    wait_idle();
    tick();
    tick();
    check("no_queued_press", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({rom_addr, ld1, ld2, num1, num2, sum, green_led, red_led,
                     round_cnt, score, busy}), 32'd0);
  endtask

  task automatic model_reset();
    m_score = 0;
    m_rounds = 0;
    m_sum = 5'd0;
    exp_num1_q.delete();
    exp_num2_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [3:0] a;
    logic [3:0] b;
    int n;
    for (int i = 0; i < 16; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    rom_mem[3] = 4'h7;
    rst = 1'b0;
    button_pulse = 1'b0;
    toggle_switch = 4'd0;
    switch_num2 = 4'd0;
    target_sum = 5'd0;
    model_reset();

    // reset and idle
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_all_zero("reset_outputs");
    repeat (4) tick();
    check_all_zero("idle_no_press");

    // winning round: ROM[3]=7, 7+13=20
    start_round(4'd3);
    finish_round(4'hD, 5'd20, 2, 1'b0);

    // losing round with an ignored press during RESULT: 7+1=8
    start_round(4'd3);
    finish_round(4'h1, 5'd20, 3, 1'b1);

    // reset mid-round in WAIT2
    start_round(4'($urandom_range(0, 15)));
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset_mid_round");
    rst = 1'b1;
    model_reset();
    tick();
    start_round(4'($urandom_range(0, 15)));
    finish_round(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1, 1'b0);

    // random rounds, roughly half wins
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      start_round(a);
      finish_round(b, ($urandom_range(0, 1) == 1) ? 5'(m_num1) + 5'(b)
                                                  : 5'($urandom_range(0, 31)),
                   $urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end

    // counter limits: 17 straight wins wraps round_cnt and saturates score
    for (int i = 0; i < 17; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      start_round(a);
      finish_round(b, 5'(m_num1) + 5'(b), 1, 1'b0);
    end
    check("score_saturated", 32'(score), 32'(CNT_MAX));

`ifdef ROUND_TIMEOUT_EN
    // timeout forces a loss, ld2 never asserts
    start_round(4'($urandom_range(0, 15)));
    m_rounds = (m_rounds + 1) % (CNT_MAX + 1);
    push_result(1'b0, 1'b1);
    target_sum = m_sum;
    n = 0;
    do begin tick(); n++; end while (!(green_led | red_led) && n < 40);
    check("timeout_to_led", 32'(n), 32'(TIMEOUT_CYCLES + 2));
    wait_idle();
    // press in the expiry cycle takes the normal path
    start_round(4'($urandom_range(0, 15)));
    b = 4'($urandom_range(0, 15));
    finish_round(b, 5'(m_num1) + 5'(b), TIMEOUT_CYCLES, 1'b0);
`else
    // without the timeout, WAIT2 holds indefinitely
    start_round(4'($urandom_range(0, 15)));
    repeat (30) tick();
    check("wait2_holds", 32'({busy, green_led, red_led}), 32'b100);
    b = 4'($urandom_range(0, 15));
    finish_round(b, 5'(m_num1) + 5'(b), 1, 1'b0);
`endif

    repeat (5) tick();
    check("queues_drained", 32'(exp_num1_q.size() + exp_num2_q.size() + exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
